// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bundle: hazard/redirect inputs and fetch/flush outputs.
// Optional misaligned-redirect trap signals exist only when PC_MISALIGN_TRAP_EN is defined.
interface pc_sequencer_if;
    logic        stall_i;
    logic        branch_taken_i;
    logic [63:0] branch_target_i;
    logic        jump_i;
    logic [63:0] jump_target_i;
    logic        imem_ready_i;
    logic [63:0] pc_o;
    logic        pc_valid_o;
    logic        flush_ifid_o;
    logic        flush_idex_o;
    logic [31:0] redirect_cnt_o;
`ifdef PC_MISALIGN_TRAP_EN
    logic [63:0] trap_vector_i;
    logic        misalign_o;
`endif

    // master is the sequencer itself; slave is the pipeline/hazard side
    modport master (
        input  stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i, imem_ready_i,
`ifdef PC_MISALIGN_TRAP_EN
        input  trap_vector_i,
        output misalign_o,
`endif
        output pc_o, pc_valid_o, flush_ifid_o, flush_idex_o, redirect_cnt_o
    );

    modport slave (
        output stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i, imem_ready_i,
`ifdef PC_MISALIGN_TRAP_EN
        output trap_vector_i,
        input  misalign_o,
`endif
        input  pc_o, pc_valid_o, flush_ifid_o, flush_idex_o, redirect_cnt_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: boot delay, sequential fetch, stalls, EX redirects and flush strobes.
// Define PC_MISALIGN_TRAP_EN to divert misaligned redirect targets to trap_vector_i.
//
// state | meaning
// BOOT  | post-reset delay, no fetch issued, waits for imem_ready_i after the count
// RUN   | sequential fetch
// STALL | PC held by hazard unit, same address re-fetched
// FLUSH | redirect taken, flush strobes high for FLUSH_CYCLES cycles
module pc_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter logic [63:0] PC_STEP      = 64'd4,
    parameter int unsigned BOOT_CYCLES  = 2,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input logic            clock,
    input logic            reset,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} state_t;

    localparam logic [31:0] BOOT_LAST  = 32'(BOOT_CYCLES - 1);
    localparam logic [1:0]  FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [31:0] boot_cnt;
    logic [1:0]  flush_cnt;
    logic [63:0] pc_q;
    logic        pc_valid_q;
    logic        flush_q;
    logic [31:0] redirect_cnt_q;

    logic        redirect;
    logic        advance;
    logic [63:0] redirect_target;
    logic [63:0] redirect_pc;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misaligned;
    logic        misalign_q;
`endif

    // jump outranks branch when both resolve in the same cycle
    always_comb begin
        redirect        = bus.jump_i | bus.branch_taken_i;
        redirect_target = bus.jump_i ? bus.jump_target_i : bus.branch_target_i;
        advance         = !bus.stall_i && bus.imem_ready_i;
`ifdef PC_MISALIGN_TRAP_EN
        misaligned  = |redirect_target[1:0];
        redirect_pc = misaligned ? bus.trap_vector_i : redirect_target;
`else
        redirect_pc = redirect_target;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= BOOT;
            boot_cnt       <= 32'd0;
            flush_cnt      <= 2'd0;
            pc_q           <= RESET_VECTOR;
            pc_valid_q     <= 1'b0;
            flush_q        <= 1'b0;
            redirect_cnt_q <= 32'd0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q     <= 1'b0;
`endif
        end else begin
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state)
                BOOT: begin
                    if (boot_cnt >= BOOT_LAST && bus.imem_ready_i) begin
                        state      <= RUN;
                        pc_valid_q <= 1'b1;
                    end else if (boot_cnt < BOOT_LAST) begin
                        boot_cnt <= boot_cnt + 32'd1;
                    end
                end
                default: begin
                    if (redirect) begin
                        pc_q      <= redirect_pc;
                        flush_q   <= 1'b1;
                        flush_cnt <= FLUSH_LAST;
                        state     <= FLUSH;
                        if (redirect_cnt_q != 32'hFFFF_FFFF)
                            redirect_cnt_q <= redirect_cnt_q + 32'd1;
`ifdef PC_MISALIGN_TRAP_EN
                        misalign_q <= misaligned;
`endif
                    end else begin
                        if (advance)
                            pc_q <= pc_q + PC_STEP;
                        if (state == FLUSH) begin
                            if (flush_cnt == 2'd0) begin
                                flush_q <= 1'b0;
                                state   <= bus.stall_i ? STALL : RUN;
                            end else begin
                                flush_cnt <= flush_cnt - 2'd1;
                            end
                        end else begin
                            state <= bus.stall_i ? STALL : RUN;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.pc_o           = pc_q;
    assign bus.pc_valid_o     = pc_valid_q;
    assign bus.flush_ifid_o   = flush_q;
    assign bus.flush_idex_o   = flush_q;
    assign bus.redirect_cnt_o = redirect_cnt_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign bus.misalign_o     = misalign_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed boot/stall/redirect/reset steps, then random traffic,
// each cycle compared against a cycle-level reference model of the fetch PC rules.
module tb_pc_sequencer;
    localparam int unsigned BOOT_CYCLES  = 2;
    localparam int unsigned FLUSH_CYCLES = 1;
    localparam logic [63:0] RESET_VECTOR = 64'h0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VECTOR(RESET_VECTOR),
        .PC_STEP     (64'd4),
        .BOOT_CYCLES (BOOT_CYCLES),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: fetching flag, boot edges seen, pc, flush cycles left, redirect count
    bit          m_fetching;
    int          m_boot_seen;
    logic [63:0] m_pc;
    int          m_flush_left;
    longint      m_cnt;
    bit          m_mis;

    task automatic model_reset();
        m_fetching   = 0;
        m_boot_seen  = 0;
        m_pc         = RESET_VECTOR;
        m_flush_left = 0;
        m_cnt        = 0;
        m_mis        = 0;
    endtask

    task automatic model_edge();
        logic [63:0] tgt;
        m_mis = 0;
        if (!m_fetching) begin
            if (m_boot_seen + 1 >= int'(BOOT_CYCLES) && bus.imem_ready_i) m_fetching = 1;
            else m_boot_seen++;
        end else if (bus.jump_i || bus.branch_taken_i) begin
            tgt = bus.jump_i ? bus.jump_target_i : bus.branch_target_i;
`ifdef PC_MISALIGN_TRAP_EN
            if (tgt[1:0] != 2'b00) begin
                tgt   = bus.trap_vector_i;
                m_mis = 1;
            end
`endif
            m_pc         = tgt;
            m_flush_left = FLUSH_CYCLES;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end else begin
            if (m_flush_left > 0) m_flush_left--;
            if (!bus.stall_i && bus.imem_ready_i) m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, bus.pc_o, m_pc);
        chk({tag, ".valid"}, 64'(bus.pc_valid_o), 64'(m_fetching));
        chk({tag, ".flush_ifid"}, 64'(bus.flush_ifid_o), 64'(m_flush_left > 0));
        chk({tag, ".flush_idex"}, 64'(bus.flush_idex_o), 64'(m_flush_left > 0));
        chk({tag, ".cnt"}, 64'(bus.redirect_cnt_o), 64'(m_cnt));
`ifdef PC_MISALIGN_TRAP_EN
        chk({tag, ".misalign"}, 64'(bus.misalign_o), 64'(m_mis));
`endif
    endtask

    task automatic step(input string tag, input logic st, input logic br, input logic [63:0] bt,
                        input logic jp, input logic [63:0] jt, input logic rdy);
        bus.stall_i         = st;
        bus.branch_taken_i  = br;
        bus.branch_target_i = bt;
        bus.jump_i          = jp;
        bus.jump_target_i   = jt;
        bus.imem_ready_i    = rdy;
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.stall_i         = 1'b0;
        bus.branch_taken_i  = 1'b0;
        bus.branch_target_i = 64'h0;
        bus.jump_i          = 1'b0;
        bus.jump_target_i   = 64'h0;
        bus.imem_ready_i    = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
        bus.trap_vector_i   = 64'h800;
`endif
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b0;

        // boot, then 0,4,8,12,16
        repeat (2) step("boot", 0, 0, 0, 0, 0, 1);
        repeat (4) step("seq", 0, 0, 0, 0, 0, 1);
        chk("seq.at16", bus.pc_o, 64'd16);

        repeat (3) step("stall", 1, 0, 0, 0, 0, 1);
        step("unstall", 0, 0, 0, 0, 0, 1);
        chk("unstall.at20", bus.pc_o, 64'd20);
        step("seq24", 0, 0, 0, 0, 0, 1);

        step("branch", 0, 1, 64'h100, 0, 0, 1);
        chk("branch.pc", bus.pc_o, 64'h100);
        chk("branch.cnt", 64'(bus.redirect_cnt_o), 64'd1);
        step("post_branch", 0, 0, 0, 0, 0, 1);
        chk("post_branch.pc", bus.pc_o, 64'h104);

        step("jump_and_branch", 0, 1, 64'h300, 1, 64'h200, 1);
        chk("jb.pc", bus.pc_o, 64'h200);
        chk("jb.cnt", 64'(bus.redirect_cnt_o), 64'd2);
        step("seq", 0, 0, 0, 0, 0, 1);

        step("jump_top", 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        step("wrap", 0, 0, 0, 0, 0, 1);
        chk("wrap.pc", bus.pc_o, 64'h0);

        repeat (3) step("not_ready", 0, 0, 0, 0, 0, 0);
        step("stall_in_flush_redirect", 1, 1, 64'h40, 0, 0, 1);
        step("stall_in_flush", 1, 0, 0, 0, 0, 1);
        step("redirect_from_stall", 1, 0, 0, 1, 64'h80, 1);

`ifdef PC_MISALIGN_TRAP_EN
        step("misalign", 0, 1, 64'h102, 0, 0, 1);
        chk("misalign.pc", bus.pc_o, 64'h800);
        step("misalign_drop", 0, 0, 0, 0, 0, 1);
`endif

        // asynchronous reset in the middle of a flush
        step("pre_rst_redirect", 0, 1, 64'h400, 0, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clock);
        #1;
        check_all("rst_hold");
        reset = 1'b0;
        repeat (3) step("boot_wait", 0, 1, 64'h500, 0, 0, 0);
        repeat (3) step("reboot", 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 9) == 0),
                 {$urandom, $urandom},
                 1'($urandom_range(0, 11) == 0),
                 {$urandom, $urandom},
                 1'($urandom_range(0, 4) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the 64-bit fetch program counter and decides its next value each cycle.
- Sequences boot after reset, sequential fetch, hazard stalls and control-flow redirects from the EX stage.
- Drives the IF/ID and ID/EX pipeline-register flush strobes.
- Sits between the hazard unit and branch/jump resolution on one side, and instruction memory plus the IF/ID register on the other.

Parameters:
- RESET_VECTOR, 64'h0, PC value loaded on reset.
- PC_STEP, 4, byte increment for sequential fetch.
- BOOT_CYCLES, 2, cycles held in BOOT after reset release before fetch starts (>=1).
- FLUSH_CYCLES, 1, cycles flush strobes stay asserted after a redirect (1..3).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high.
- stall_i  input  1  hazard unit requests freezing the PC.
- branch_taken_i  input  1  EX stage resolved a taken conditional branch.
- branch_target_i  input  64  branch target address.
- jump_i  input  1  EX stage JAL/JALR.
- jump_target_i  input  64  jump target address.
- imem_ready_i  input  1  instruction memory can accept an address.
- pc_o  output  64  current fetch address.
- pc_valid_o  output  1  pc_o is a real fetch request this cycle.
- flush_ifid_o  output  1  clear IF/ID register.
- flush_idex_o  output  1  clear ID/EX register.
- redirect_cnt_o  output  32  count of redirects since reset, saturating.

Behaviour:
- Reset is asynchronous and active-high: clock clock, reset reset.
- Values while reset is high: pc_o=RESET_VECTOR, pc_valid_o=0, flush_ifid_o=0, flush_idex_o=0, redirect_cnt_o=0, state=BOOT, boot counter=0.
- The FSM has four states: BOOT, RUN, STALL, FLUSH. All outputs are registered and update on the rising clock edge.
- BOOT:
  - Counts BOOT_CYCLES cycles.
  - After the count, moves to RUN on the first cycle with imem_ready_i=1.
  - pc_valid_o=0 and pc_o=RESET_VECTOR throughout.
  - Redirect and stall inputs are ignored.
- RUN:
  - pc_valid_o=1.
  - Next-PC priority (highest first): jump_i, then branch_taken_i, then stall_i or !imem_ready_i, then pc_o+PC_STEP.
  - Arithmetic is modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- Redirect (jump_i or branch_taken_i in RUN or STALL):
  - pc_o takes the selected target on the next edge.
  - flush_ifid_o and flush_idex_o go high for exactly FLUSH_CYCLES cycles, starting the cycle after.
  - State goes to FLUSH and redirect_cnt_o increments, saturating at 32'hFFFF_FFFF.
  - If jump_i and branch_taken_i are both high, jump_target_i is taken and the count increments once.
- STALL:
  - Entered from RUN when stall_i=1 with no redirect.
  - pc_o holds and pc_valid_o stays 1, so fetch of the same address repeats.
  - Returns to RUN the cycle after stall_i=0.
  - A redirect overrides the stall in the same cycle.
- FLUSH:
  - pc_valid_o=1 and pc_o advances by PC_STEP per cycle (subject to stall_i and imem_ready_i).
  - Returns to RUN after FLUSH_CYCLES cycles.
  - A new redirect during FLUSH reloads pc_o and restarts the flush counter.
- !imem_ready_i in RUN, STALL or FLUSH holds pc_o, the same as a stall, without changing state.
- Reset asserted mid-operation returns to the reset values immediately, without waiting for a clock edge. Any flush in progress is abandoned.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- When defined:
  - Adds input trap_vector_i[63:0] and output misalign_o (1 bit).
  - A redirect target with bits[1:0] != 0 loads trap_vector_i instead of the target.
  - misalign_o pulses for 1 cycle, aligned with the flush strobes.
  - Flush and count behaviour is unchanged.
- When undefined: targets load unmodified, and the port and logic are absent.

Test Plan:
- Reset, BOOT_CYCLES=2, imem_ready_i=1 -> pc_valid_o=0 for 2 cycles after release. Then pc_o=0,4,8,12 on successive cycles.
- At pc_o=16 assert stall_i for 3 cycles -> pc_o stays 16 for 3 cycles, then 20.
- branch_taken_i=1 with target 64'h100 while at pc_o=24 -> next pc_o=0x100. Flush strobes high 1 cycle, redirect_cnt_o=1, then pc_o=0x104.
- jump_i=1 (target 0x200) and branch_taken_i=1 (target 0x300) in the same cycle -> pc_o=0x200 and redirect_cnt_o increments by 1 only.
- Assert reset asynchronously mid-FLUSH -> outputs return to reset values immediately, flush strobes drop, BOOT restarts.
- With PC_MISALIGN_TRAP_EN: target 0x102, trap_vector_i=0x800 -> pc_o=0x800 and misalign_o pulses 1 cycle.
